// File: rtl/merge_split_pkg.sv
// merge_split shared types: FSM states, frame count, merge-side widths.
// Imported by the frame splitter and the merge FIFO.
package merge_split_pkg;

  localparam int DW_DEF   = 32;
  localparam int SHW_DEF  = 32;
  localparam int THW_DEF  = 6;
  localparam int THHW_DEF = 32;

  localparam int NFRAMES = 1 << THW_DEF;

  typedef logic [DW_DEF-1:0]   triple_t;
  typedef logic [SHW_DEF-1:0]  sh_t;
  typedef logic [THHW_DEF-1:0] thh_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    FLUSH
  } state_t;

  function automatic int nframes(input int thw);
    return 1 << thw;
  endfunction

endpackage

// File: rtl/merge_split.sv
// merge_split: re-segments one merged, th-sorted frame into 2^THW frames.
// Missing th indices become one-beat empty marker frames.
module merge_split
  import merge_split_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int SHW  = SHW_DEF,
  parameter int THW  = THW_DEF,
  parameter int THHW = THHW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  output logic            i_ready,
  input  logic            i_valid,
  input  logic            i_last,
  input  logic [DW-1:0]   i_data,
  input  logic [THW-1:0]  i_th,
  input  logic [SHW-1:0]  i_sh,
  input  logic [THHW-1:0] i_thh,
  input  logic            o_ready,
  output logic            o_valid,
  output logic            o_last,
  output logic            o_empty,
  output logic [DW-1:0]   o_data,
  output logic [THW-1:0]  o_th,
  output logic [SHW-1:0]  o_sh,
  output logic [THHW-1:0] o_thh,
  output logic            o_err
);

  localparam int NF = (THW == THW_DEF) ? NFRAMES : nframes(THW);
  localparam logic [THW:0] NF_E = NF[THW:0];

  state_t          state;
  logic [DW-1:0]   h_data;
  logic [THW-1:0]  h_th;
  logic            h_last;
  logic [THW:0]    e;
  logic [SHW-1:0]  sh_q;
  logic [THHW-1:0] thh_q;
  logic            err_q;

  logic [THW-1:0]  in_th;
  logic [THW:0]    h_nxt;
  logic [THW:0]    e_inc;
  logic            th_gt;
  logic            emit_ok;
  logic            marker;
  logic            run_last;
  logic            emit_hs;
  logic            mark_hs;
  logic            acc;

  // Handshake and frame-boundary decode from H, E and the lookahead beat.
  always_comb begin
    in_th    = (i_th < h_th) ? h_th : i_th;
    h_nxt    = {1'b0, h_th} + 1'b1;
    e_inc    = e + 1'b1;
    th_gt    = {1'b0, h_th} > e;
    emit_ok  = (state == RUN) && !th_gt
               && (i_valid || h_last);
    marker   = (state == GAP) || (state == FLUSH);
    run_last = h_last || (in_th != h_th);
    emit_hs  = emit_ok && o_ready;
    mark_hs  = marker && o_ready;
    i_ready  = !reset
               && ((state == IDLE)
                   || (emit_hs && !h_last));
    acc      = i_valid && i_ready;
  end

  // Output beat: held data beat, empty marker, or idle zeros.
  always_comb begin
    o_valid = 1'b0;
    o_last  = 1'b0;
    o_empty = 1'b0;
    o_data  = '0;
    o_th    = '0;
    if (!reset) begin
      unique case (1'b1)
        marker: begin
          o_valid = 1'b1;
          o_last  = 1'b1;
          o_empty = 1'b1;
          o_th    = e[THW-1:0];
        end
        emit_ok: begin
          o_valid = 1'b1;
          o_last  = run_last;
          o_data  = h_data;
          o_th    = h_th;
        end
        default: ;
      endcase
    end
  end

  assign o_sh  = sh_q;
  assign o_thh = thh_q;
  assign o_err = err_q;

  // FSM: H load/reload, open-frame counter and sticky order error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      h_data <= '0;
      h_th   <= '0;
      h_last <= 1'b0;
      e      <= '0;
      sh_q   <= '0;
      thh_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            h_data <= i_data;
            h_th   <= i_th;
            h_last <= i_last;
            sh_q   <= i_sh;
            thh_q  <= i_thh;
            e      <= '0;
            state  <= (i_th != '0) ? GAP : RUN;
          end
        end
        RUN: begin
          if (th_gt) begin
            state <= GAP;
          end else if (emit_hs) begin
            if (run_last) e <= h_nxt;
            if (h_last) begin
              h_last <= 1'b0;
              if (h_nxt == NF_E) begin
                e     <= '0;
                state <= IDLE;
              end else begin
                state <= FLUSH;
              end
            end else if (acc) begin
              h_data <= i_data;
              h_th   <= in_th;
              h_last <= i_last;
              if (i_th < h_th) err_q <= 1'b1;
              if (run_last && ({1'b0, in_th} > h_nxt))
                state <= GAP;
            end
          end
        end
        GAP: begin
          if (mark_hs) begin
            e <= e_inc;
            if (e_inc == {1'b0, h_th}) state <= RUN;
          end
        end
        FLUSH: begin
          if (mark_hs) begin
            if (e_inc == NF_E) begin
              e     <= '0;
              state <= IDLE;
            end else begin
              e <= e_inc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
